// File: rtl/game_referee_if.sv
// game_referee_if: bundles the round controls and the round-status outputs
// of game_referee. The master side drives start/hits/vsync and reads status.
interface game_referee_if;
   logic       start;
   logic       player_hit;
   logic       enemy_hit;
   logic       vsync;
   logic       win;
   logic       loose;
   logic       playing;
   logic [3:0] player_hp;
   logic [3:0] enemy_hp;
   logic [7:0] time_left;

   modport master (
      output start, player_hit, enemy_hit, vsync,
      input  win, loose, playing, player_hp, enemy_hp, time_left
   );

   modport slave (
      input  start, player_hit, enemy_hit, vsync,
      output win, loose, playing, player_hp, enemy_hp, time_left
   );
endinterface

// File: rtl/game_referee.sv
// game_referee: round-outcome FSM (IDLE/PLAY/WIN/LOOSE) that tracks both
// hit-point counts and a vsync-derived second timer, and holds the result.
// Ports: clk60MHz, rst (sync, active-high), bus (game_referee_if.slave):
//   in  start, player_hit, enemy_hit, vsync
//   out win, loose, playing, player_hp[3:0], enemy_hp[3:0], time_left[7:0]
module game_referee #(
   parameter int HP_INIT        = 3,
   parameter int ROUND_SECONDS  = 60,
   parameter int FRAMES_PER_SEC = 60,
   parameter int RESULT_FRAMES  = 180
) (
   input  logic          clk60MHz,
   input  logic          rst,
   game_referee_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_WIN   = 2'd2,
      S_LOOSE = 2'd3
   } state_t;

   localparam logic [3:0] HP0    = 4'(HP_INIT);
   localparam logic [7:0] T0     = 8'(ROUND_SECONDS);
   localparam logic [7:0] FPS_M1 = 8'(FRAMES_PER_SEC - 1);
   localparam logic [9:0] RF_M1  = 10'(RESULT_FRAMES - 1);

   state_t     state_q, state_d;
   logic [3:0] php_q, php_d;
   logic [3:0] ehp_q, ehp_d;
   logic [7:0] time_q, time_d;
   logic [7:0] frame_q, frame_d;
   logic [9:0] hold_q, hold_d;
   logic       vsync_d_q;
   logic       tick_q;

   // The edge is registered, so a frame tick acts one cycle after
   // the vsync rising edge is sampled.
   always_ff @(posedge clk60MHz) begin
      if (rst) begin
         state_q   <= S_IDLE;
         php_q     <= HP0;
         ehp_q     <= HP0;
         time_q    <= T0;
         frame_q   <= '0;
         hold_q    <= '0;
         vsync_d_q <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         php_q     <= php_d;
         ehp_q     <= ehp_d;
         time_q    <= time_d;
         frame_q   <= frame_d;
         hold_q    <= hold_d;
         vsync_d_q <= bus.vsync;
         tick_q    <= bus.vsync & ~vsync_d_q;
      end
   end

   always_comb begin
      state_d = state_q;
      php_d   = php_q;
      ehp_d   = ehp_q;
      time_d  = time_q;
      frame_d = frame_q;
      hold_d  = hold_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_PLAY;
               php_d   = HP0;
               ehp_d   = HP0;
               time_d  = T0;
               frame_d = '0;
            end
         end
         S_PLAY: begin
            if (bus.player_hit && php_q != 4'd0)
               php_d = php_q - 4'd1;
            if (bus.enemy_hit && ehp_q != 4'd0)
               ehp_d = ehp_q - 4'd1;
            if (tick_q) begin
               if (frame_q == FPS_M1) begin
                  frame_d = '0;
                  time_d  = time_q - 8'd1;
               end else begin
                  frame_d = frame_q + 8'd1;
               end
            end
            hold_d = '0;
            // Decided on next-state values: player death outranks
            // enemy death, which outranks the timeout; a tie loses.
            if (php_d == 4'd0)
               state_d = S_LOOSE;
            else if (ehp_d == 4'd0)
               state_d = S_WIN;
            else if (time_d == 8'd0)
               state_d = (php_d > ehp_d) ? S_WIN : S_LOOSE;
         end
         S_WIN, S_LOOSE: begin
            if (tick_q) begin
               if (hold_q == RF_M1)
                  state_d = S_IDLE;
               else
                  hold_d = hold_q + 10'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.win       = (state_q == S_WIN);
   assign bus.loose     = (state_q == S_LOOSE);
   assign bus.playing   = (state_q == S_PLAY);
   assign bus.player_hp = php_q;
   assign bus.enemy_hp  = ehp_q;
   assign bus.time_left = time_q;
endmodule

// File: tb/tb_game_referee.sv
// tb_game_referee: vector-table and scoreboard bench for game_referee
// with HP_INIT=3, FRAMES_PER_SEC=2, ROUND_SECONDS=3, RESULT_FRAMES=4.
module tb_game_referee;
   logic clk = 1'b0;
   logic rst = 1'b1;

   game_referee_if bus ();

   game_referee #(
      .HP_INIT       (3),
      .ROUND_SECONDS (3),
      .FRAMES_PER_SEC(2),
      .RESULT_FRAMES (4)
   ) dut (
      .clk60MHz(clk),
      .rst     (rst),
      .bus     (bus)
   );

   always #8 clk = ~clk;

   // inputs {rst,start,player_hit,enemy_hit,vsync}
   localparam logic [4:0] N  = 5'b00000;
   localparam logic [4:0] R  = 5'b10000;
   localparam logic [4:0] S  = 5'b01000;
   localparam logic [4:0] P  = 5'b00100;
   localparam logic [4:0] E  = 5'b00010;
   localparam logic [4:0] PE = 5'b00110;
   localparam logic [4:0] V  = 5'b00001;
   // flags {win,loose,playing}
   localparam logic [2:0] IDL = 3'b000;
   localparam logic [2:0] PLY = 3'b001;
   localparam logic [2:0] LOS = 3'b010;
   localparam logic [2:0] WIN = 3'b100;

   typedef struct {
      string      n;
      logic [4:0] in;
      logic [2:0] fl;
      logic [3:0] ph;
      logic [3:0] eh;
      logic [7:0] t;
   } vec_t;

   typedef struct {
      string       n;
      logic [18:0] o;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   passed = 0;
   int   total  = 0;

   function automatic vec_t mk(string n, logic [4:0] in, logic [2:0] fl,
                               int ph, int eh, int t);
      vec_t v;
      v.n  = n;
      v.in = in;
      v.fl = fl;
      v.ph = 4'(ph);
      v.eh = 4'(eh);
      v.t  = 8'(t);
      return v;
   endfunction

   task automatic step(vec_t v);
      exp_t        e;
      logic [18:0] a;
      @(negedge clk);
      rst            = v.in[4];
      bus.start      = v.in[3];
      bus.player_hit = v.in[2];
      bus.enemy_hit  = v.in[1];
      bus.vsync      = v.in[0];
      e.n = v.n;
      e.o = {v.fl, v.ph, v.eh, v.t};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      a = {bus.win, bus.loose, bus.playing,
           bus.player_hp, bus.enemy_hp, bus.time_left};
      total++;
      if (a === e.o)
         passed++;
      else
         $display("FAIL %s: got wlp=%b php=%0d ehp=%0d t=%0d, want wlp=%b php=%0d ehp=%0d t=%0d",
                  e.n, a[18:16], a[15:12], a[11:8], a[7:0],
                  e.o[18:16], e.o[15:12], e.o[11:8], e.o[7:0]);
   endtask

   // One vsync pulse per tick; the effect shows one vector later.
   task automatic timed_round(string n, int ph, int eh, int ticks,
                              logic [2:0] final_fl);
      int t = 3;
      for (int i = 1; i <= ticks; i++) begin
         step(mk({n, "_v"}, V, PLY, ph, eh, t));
         if (i % 2 == 0) t--;
         step(mk({n, "_tk"}, N, (t == 0) ? final_fl : PLY, ph, eh, t));
      end
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.player_hit = 1'b0;
      bus.enemy_hit  = 1'b0;
      bus.vsync      = 1'b0;

      tbl.push_back(mk("rst", R, IDL, 3, 3, 3));
      tbl.push_back(mk("idle", N, IDL, 3, 3, 3));
      tbl.push_back(mk("start", S, PLY, 3, 3, 3));
      tbl.push_back(mk("eh1", E, PLY, 3, 2, 3));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk("gap1", N, PLY, 3, 2, 3));
      tbl.push_back(mk("eh2", E, PLY, 3, 1, 3));
      for (int k = 0; k < 4; k++)
         tbl.push_back(mk("gap2", N, PLY, 3, 1, 3));
      tbl.push_back(mk("eh3_win", E, WIN, 3, 0, 3));
      tbl.push_back(mk("win_hits", PE, WIN, 3, 0, 3));
      tbl.push_back(mk("win_start", S, WIN, 3, 0, 3));
      for (int k = 0; k < 3; k++) begin
         tbl.push_back(mk("hold_v", V, WIN, 3, 0, 3));
         tbl.push_back(mk("hold_tk", N, WIN, 3, 0, 3));
      end
      tbl.push_back(mk("hold4_v", V, WIN, 3, 0, 3));
      tbl.push_back(mk("to_idle", N, IDL, 3, 0, 3));
      tbl.push_back(mk("idle_hits", PE, IDL, 3, 0, 3));
      tbl.push_back(mk("idle_v", V, IDL, 3, 0, 3));
      tbl.push_back(mk("idle_tk", N, IDL, 3, 0, 3));
      tbl.push_back(mk("restart", S, PLY, 3, 3, 3));
      tbl.push_back(mk("ph1", P, PLY, 2, 3, 3));
      tbl.push_back(mk("ph2", P, PLY, 1, 3, 3));
      tbl.push_back(mk("eh_a", E, PLY, 1, 2, 3));
      tbl.push_back(mk("eh_b", E, PLY, 1, 1, 3));
      tbl.push_back(mk("both_loose", PE, LOS, 0, 0, 3));
      tbl.push_back(mk("los_start", S, LOS, 0, 0, 3));
      tbl.push_back(mk("rst_loose", R, IDL, 3, 3, 3));

      for (int i = 0; i < tbl.size(); i++)
         step(tbl[i]);

      // Timeout with player ahead, then a tie.
      step(mk("t3_start", S, PLY, 3, 3, 3));
      step(mk("t3_eh", E, PLY, 3, 2, 3));
      timed_round("t3_win", 3, 2, 6, WIN);
      step(mk("t3_rst", R, IDL, 3, 3, 3));
      step(mk("t3b_start", S, PLY, 3, 3, 3));
      timed_round("t3_tie", 3, 3, 6, LOS);
      step(mk("t3b_rst", R, IDL, 3, 3, 3));

      // Reset mid-round with a pending frame count and tick.
      step(mk("t5_start", S, PLY, 3, 3, 3));
      step(mk("t5_eh1", E, PLY, 3, 2, 3));
      step(mk("t5_eh2", E, PLY, 3, 1, 3));
      step(mk("t5_v", V, PLY, 3, 1, 3));
      step(mk("t5_tk", N, PLY, 3, 1, 3));
      step(mk("t5_v2", V, PLY, 3, 1, 3));
      step(mk("t5_rst", R, IDL, 3, 3, 3));
      step(mk("t5_ph", P, IDL, 3, 3, 3));
      step(mk("t5_eh", E, IDL, 3, 3, 3));
      step(mk("t5_start", S, PLY, 3, 3, 3));
      timed_round("t5_frame0", 3, 3, 2, LOS);

      // Hit on the final timer tick: hp rule wins.
      step(mk("t6_rst", R, IDL, 3, 3, 3));
      step(mk("t6_start", S, PLY, 3, 3, 3));
      step(mk("t6_ph1", P, PLY, 2, 3, 3));
      step(mk("t6_ph2", P, PLY, 1, 3, 3));
      timed_round("t6", 1, 3, 5, LOS);
      step(mk("t6_v6", V, PLY, 1, 3, 1));
      step(mk("t6_hit_tick", P, LOS, 0, 3, 0));
      step(mk("t6_los_hits", PE, LOS, 0, 3, 0));
      step(mk("t6_rst2", R, IDL, 3, 3, 3));
      step(mk("t6_idle_hit", P, IDL, 3, 3, 3));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
